// File: rtl/pt_stage_sequencer.sv
// rtl/pt_stage_sequencer.sv - Pan-Tompkins stage chain sequencer
// Clears, gates, warms up, drains and watchdogs the differentiator/squarer/integrator chain.
module pt_stage_sequencer #(
    parameter int ND  = 4,
    parameter int NW  = 30,
    parameter int LAT = 2,
    parameter int TMO = 1000,
    parameter int CW  = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic          stage_clr_o,
    output logic          stage_en_o,
    output logic          out_valid_o,
    output logic          warm_done_o,
    output logic          timeout_err_o,
    output logic [2:0]    state_o,
    output logic [CW-1:0] sample_cnt_o
);

    localparam int WARM = ND + NW - 1;
    localparam int WW   = $clog2(WARM) + 1;
    localparam int TW   = $clog2(TMO) + 1;
    localparam int DW   = $clog2(LAT) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        WARMUP = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [LAT-1:0]  tag_sr_q, tag_sr_d;
    logic [LAT-1:0]  tag_vec;
    logic [CW-1:0]   sample_cnt_q, sample_cnt_d;
    logic            timeout_err_q, timeout_err_d;
    logic            stage_clr_q, stage_clr_d;
    logic            active, accept, tag, tmo_hit;

    always_comb begin
        active  = (state_q == WARMUP) || (state_q == RUN);
        accept  = s_valid_i & active;
        tag     = accept & (state_q == RUN);
        tmo_hit = active & ~accept & (timer_q == TW'(TMO - 1));

        state_d       = state_q;
        wcnt_d        = wcnt_q;
        drain_d       = drain_q;
        sample_cnt_d  = sample_cnt_q;
        timeout_err_d = timeout_err_q;
        if (!active || accept) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                wcnt_d        = '0;
                sample_cnt_d  = '0;
                timeout_err_d = 1'b0;
                state_d       = WARMUP;
            end
            WARMUP, RUN: begin
                if (state_q == WARMUP && accept) begin
                    wcnt_d = wcnt_q + WW'(1);
                    if (wcnt_q == WW'(WARM - 1)) begin
                        state_d = RUN;
                    end
                end
                // stop outranks the watchdog, and both outrank the warm-up promotion
                if (stop_i) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else if (tmo_hit) begin
                    state_d       = DRAIN;
                    drain_d       = '0;
                    timeout_err_d = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DW'(LAT - 1)) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (tag && sample_cnt_q != '1) begin
            sample_cnt_d = sample_cnt_q + CW'(1);
        end

        tag_vec     = '0;
        tag_vec[0]  = tag;
        tag_sr_d    = (tag_sr_q << 1) | tag_vec;
        stage_clr_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            timer_q       <= '0;
            drain_q       <= '0;
            tag_sr_q      <= '0;
            sample_cnt_q  <= '0;
            timeout_err_q <= 1'b0;
            stage_clr_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            timer_q       <= timer_d;
            drain_q       <= drain_d;
            tag_sr_q      <= tag_sr_d;
            sample_cnt_q  <= sample_cnt_d;
            timeout_err_q <= timeout_err_d;
            stage_clr_q   <= stage_clr_d;
        end
    end

    assign s_ready_o     = active;
    assign stage_en_o    = accept;
    assign stage_clr_o   = stage_clr_q;
    assign out_valid_o   = tag_sr_q[LAT-1];
    assign warm_done_o   = (state_q == RUN);
    assign timeout_err_o = timeout_err_q;
    assign state_o       = state_q;
    assign sample_cnt_o  = sample_cnt_q;

endmodule

// File: tb/tb_pt_stage_sequencer.sv
// tb/tb_pt_stage_sequencer.sv - directed self-checking bench for pt_stage_sequencer
module tb_pt_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, s_valid;
    logic       s_ready, stage_clr, stage_en, out_valid, warm_done, timeout_err;
    logic [2:0] state;
    logic [3:0] sample_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int en_cnt = 0;
    int ov_cnt = 0;
    int first_ov = -1;
    int s34 = 0;
    int en0, ov0, ovr;

    pt_stage_sequencer #(.ND(4), .NW(30), .LAT(2), .TMO(10), .CW(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .stop_i       (stop),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .stage_clr_o  (stage_clr),
        .stage_en_o   (stage_en),
        .out_valid_o  (out_valid),
        .warm_done_o  (warm_done),
        .timeout_err_o(timeout_err),
        .state_o      (state),
        .sample_cnt_o (sample_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (stage_en) en_cnt = en_cnt + 1;
        if (out_valid) begin
            ov_cnt = ov_cnt + 1;
            if (first_ov < 0) first_ov = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_state", 32'(state), 0);
        chk("rst_ready", 32'(s_ready), 0);
        chk("rst_clr", 32'(stage_clr), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_warm", 32'(warm_done), 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        chk("rst_cnt", 32'(sample_cnt), 0);
        s_valid = 1'b1; #1;
        chk("idle_en", 32'(stage_en), 0);
        s_valid = 1'b0;
        step();
        chk("idle_hold", 32'(state), 0);

        // start, 40 back-to-back samples, stop on sample 40
        start = 1'b1; step(); start = 1'b0;
        chk("t1_clear", 32'(state), 1);
        chk("t1_clr_hi", 32'(stage_clr), 1);
        chk("t1_clr_rdy", 32'(s_ready), 0);
        step();
        chk("t1_warm", 32'(state), 2);
        chk("t1_clr_lo", 32'(stage_clr), 0);
        chk("t1_rdy", 32'(s_ready), 1);
        en0 = en_cnt; ov0 = ov_cnt;
        for (int i = 1; i <= 40; i++) begin
            s_valid = 1'b1;
            if (i == 34) s34 = cyc;
            if (i == 40) begin
                stop = 1'b1; #1;
                chk("t2_stop_en", 32'(stage_en), 1);
            end
            step();
            if (i == 32) chk("t1_still_warm", 32'(state), 2);
            if (i == 33) begin
                chk("t1_run", 32'(state), 3);
                chk("t1_warm_done", 32'(warm_done), 1);
                chk("t1_cnt0", 32'(sample_cnt), 0);
            end
        end
        s_valid = 1'b0; stop = 1'b0;
        chk("t2_drain1", 32'(state), 4);
        chk("t2_drain_rdy", 32'(s_ready), 0);
        chk("t1_cnt7", 32'(sample_cnt), 7);
        step();
        chk("t2_drain2", 32'(state), 4);
        chk("t2_ov40", 32'(out_valid), 1);
        step();
        chk("t2_idle", 32'(state), 0);
        chk("t2_idle_rdy", 32'(s_ready), 0);
        chk("t1_en_total", 32'(en_cnt - en0), 40);
        chk("t1_ov_total", 32'(ov_cnt - ov0), 7);
        chk("t1_first_ov", 32'(first_ov - s34), 2);

        // watchdog: stall after 5 samples
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("t3_warm", 32'(state), 2);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; step();
        end
        s_valid = 1'b0;
        repeat (9) step();
        chk("t3_pre_tmo", 32'(state), 2);
        chk("t3_pre_err", 32'(timeout_err), 0);
        step();
        chk("t3_drain", 32'(state), 4);
        chk("t3_err", 32'(timeout_err), 1);
        step(); step();
        chk("t3_idle", 32'(state), 0);
        chk("t3_err_sticky", 32'(timeout_err), 1);
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("t3_restart", 32'(state), 2);
        chk("t3_err_clr", 32'(timeout_err), 0);

        // stop coincides with the watchdog firing
        repeat (9) step();
        stop = 1'b1;
        chk("t4_pre", 32'(state), 2);
        step(); stop = 1'b0;
        chk("t4_drain", 32'(state), 4);
        chk("t4_no_err", 32'(timeout_err), 0);
        step(); step();
        chk("t4_idle", 32'(state), 0);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("t4_start_stop", 32'(state), 1);
        step();
        chk("t4_warm", 32'(state), 2);

        // saturation with CW=4, then start ignored in RUN
        for (int i = 0; i < 53; i++) begin
            s_valid = 1'b1; step();
        end
        s_valid = 1'b0;
        chk("t6_sat", 32'(sample_cnt), 15);
        chk("t6_run", 32'(state), 3);
        start = 1'b1; step(); start = 1'b0;
        chk("t6_start_ign", 32'(state), 3);
        chk("t6_no_clr", 32'(stage_clr), 0);

        // reset with a tag in flight
        s_valid = 1'b1; step();
        rst = 1'b1; step(); rst = 1'b0; s_valid = 1'b0;
        chk("t5_state", 32'(state), 0);
        chk("t5_ready", 32'(s_ready), 0);
        chk("t5_clr", 32'(stage_clr), 0);
        chk("t5_ov", 32'(out_valid), 0);
        chk("t5_warm", 32'(warm_done), 0);
        chk("t5_tmo", 32'(timeout_err), 0);
        chk("t5_cnt", 32'(sample_cnt), 0);
        ovr = ov_cnt;
        repeat (3) step();
        chk("t5_no_ov", 32'(ov_cnt - ovr), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
